// File: rtl/reg_status_file_pkg.sv
// Shared sizing constants for the architectural register file and its rename status.
package reg_status_file_pkg;

    localparam int RSF_ROB_SIZE   = 16;
    localparam int RSF_ROB_SIZE_W = $clog2(RSF_ROB_SIZE);
    localparam int RSF_REG_NUM    = 32;
    localparam int RSF_XLEN       = 32;
    localparam int RSF_IDX_W      = $clog2(RSF_REG_NUM);

endpackage

// File: rtl/reg_read_port.sv
// One dispatch read port: x0 forcing, same-cycle commit bypass, otherwise the stored entry.
module reg_read_port
    import reg_status_file_pkg::*;
#(
    parameter int TAG_W = RSF_ROB_SIZE_W,
    parameter int XLEN  = RSF_XLEN,
    parameter int IDX_W = RSF_IDX_W
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [XLEN-1:0]  entry_val,
    input  logic             entry_busy,
    input  logic [TAG_W-1:0] entry_tag,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [XLEN-1:0]  commit_val,
    output logic [XLEN-1:0]  rd_val,
    output logic             rd_busy,
    output logic [TAG_W-1:0] rd_tag
);

    always_comb begin
        rd_val  = entry_val;
        rd_busy = entry_busy;
        rd_tag  = entry_tag;
        if (idx == '0) begin
            rd_val  = '0;
            rd_busy = 1'b0;
            rd_tag  = '0;
        end else if (commit_valid && entry_busy && (entry_tag == commit_tag)) begin
            // The producer is committing right now, so dispatch can take the value immediately.
            rd_val  = commit_val;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file x0..x31 with per-register busy bit and ROB tag for the Tomasulo core.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int REG_NUM = RSF_REG_NUM,
    parameter int TAG_W   = RSF_ROB_SIZE_W,
    parameter int XLEN    = RSF_XLEN
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rename_valid,
    input  logic [RSF_IDX_W-1:0] rename_rd,
    input  logic [TAG_W-1:0]     rename_tag,
    input  logic                 commit_valid,
    input  logic [RSF_IDX_W-1:0] commit_rd,
    input  logic [TAG_W-1:0]     commit_tag,
    input  logic [XLEN-1:0]      commit_val,
    input  logic                 predict_fail,
    input  logic [RSF_IDX_W-1:0] rs1_idx,
    output logic [XLEN-1:0]      rs1_val,
    output logic                 rs1_busy,
    output logic [TAG_W-1:0]     rs1_tag,
    input  logic [RSF_IDX_W-1:0] rs2_idx,
    output logic [XLEN-1:0]      rs2_val,
    output logic                 rs2_busy,
    output logic [TAG_W-1:0]     rs2_tag
);

    logic [REG_NUM-1:0][XLEN-1:0]  regs;
    logic [REG_NUM-1:0]            busy;
    logic [REG_NUM-1:0][TAG_W-1:0] tags;

    // Rename is applied after commit so it wins busy/tag on a same-register collision.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            regs <= '0;
            busy <= '0;
            tags <= '0;
        end else if (rdy_in) begin
            if (commit_valid && (commit_rd != '0)) begin
                regs[commit_rd] <= commit_val;
                if (tags[commit_rd] == commit_tag) begin
                    busy[commit_rd] <= 1'b0;
                end
            end
            if (predict_fail) begin
                busy <= '0;
            end else if (rename_valid && (rename_rd != '0)) begin
                busy[rename_rd] <= 1'b1;
                tags[rename_rd] <= rename_tag;
            end
        end
    end

    reg_read_port #(
        .TAG_W (TAG_W),
        .XLEN  (XLEN),
        .IDX_W (RSF_IDX_W)
    ) u_rs1_port (
        .idx          (rs1_idx),
        .entry_val    (regs[rs1_idx]),
        .entry_busy   (busy[rs1_idx]),
        .entry_tag    (tags[rs1_idx]),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_val   (commit_val),
        .rd_val       (rs1_val),
        .rd_busy      (rs1_busy),
        .rd_tag       (rs1_tag)
    );

    reg_read_port #(
        .TAG_W (TAG_W),
        .XLEN  (XLEN),
        .IDX_W (RSF_IDX_W)
    ) u_rs2_port (
        .idx          (rs2_idx),
        .entry_val    (regs[rs2_idx]),
        .entry_busy   (busy[rs2_idx]),
        .entry_tag    (tags[rs2_idx]),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_val   (commit_val),
        .rd_val       (rs2_val),
        .rd_busy      (rs2_busy),
        .rd_tag       (rs2_tag)
    );

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: behavioural model predicts each cycle's reads into a scoreboard queue.
module tb_reg_status_file;
    import reg_status_file_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rename_valid;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_tag;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_val;
    logic        predict_fail;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_val;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [4:0]  rs2_idx;
    logic [31:0] rs2_val;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;

    reg_status_file dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rename_valid (rename_valid),
        .rename_rd    (rename_rd),
        .rename_tag   (rename_tag),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_val   (commit_val),
        .predict_fail (predict_fail),
        .rs1_idx      (rs1_idx),
        .rs1_val      (rs1_val),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs2_idx      (rs2_idx),
        .rs2_val      (rs2_val),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
        logic        busy;
        logic [3:0]  tag;
        logic        chk_tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    function automatic exp_t modelRead(input logic [4:0] idx);
        exp_t e;
        e.idx = idx; e.val = '0; e.busy = 1'b0; e.tag = '0; e.chk_tag = 1'b1;
        if (idx != 5'd0) begin
            if (commit_valid && m_busy[idx] && (m_tag[idx] == commit_tag)) begin
                e.val     = commit_val;
                e.chk_tag = 1'b0;
            end else begin
                e.val     = m_reg[idx];
                e.busy    = m_busy[idx];
                e.tag     = m_tag[idx];
                e.chk_tag = m_busy[idx];
            end
        end
        return e;
    endfunction

    task automatic modelUpdate();
        if (rdy_in) begin
            if (commit_valid && commit_rd != 5'd0) begin
                m_reg[commit_rd] = commit_val;
                if (m_tag[commit_rd] == commit_tag) m_busy[commit_rd] = 1'b0;
            end
            if (predict_fail) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (rename_valid && rename_rd != 5'd0) begin
                m_busy[rename_rd] = 1'b1;
                m_tag[rename_rd]  = rename_tag;
            end
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [4:0] rrd, input logic [3:0] rtag,
                                 input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                                 input logic [31:0] cval, input logic pf, input logic rdy,
                                 input logic [4:0] r1, input logic [4:0] r2);
        rename_valid = rv;  rename_rd = rrd;  rename_tag = rtag;
        commit_valid = cv;  commit_rd = crd;  commit_tag = ctag;  commit_val = cval;
        predict_fail = pf;  rdy_in = rdy;     rs1_idx = r1;       rs2_idx = r2;
        sb.push_back(modelRead(r1));
        sb.push_back(modelRead(r2));
    endtask

    task automatic checkReads();
        exp_t e;
        e = sb.pop_front();
        checkOutput($sformatf("rs1_val x%0d", e.idx), rs1_val, e.val);
        checkOutput($sformatf("rs1_busy x%0d", e.idx), {31'd0, rs1_busy}, {31'd0, e.busy});
        if (e.chk_tag) checkOutput($sformatf("rs1_tag x%0d", e.idx), {28'd0, rs1_tag}, {28'd0, e.tag});
        e = sb.pop_front();
        checkOutput($sformatf("rs2_val x%0d", e.idx), rs2_val, e.val);
        checkOutput($sformatf("rs2_busy x%0d", e.idx), {31'd0, rs2_busy}, {31'd0, e.busy});
        if (e.chk_tag) checkOutput($sformatf("rs2_tag x%0d", e.idx), {28'd0, rs2_tag}, {28'd0, e.tag});
    endtask

    // One full cycle: drive, check combinational reads before the edge, then advance the model.
    task automatic step(input logic rv, input logic [4:0] rrd, input logic [3:0] rtag,
                        input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                        input logic [31:0] cval, input logic pf, input logic rdy,
                        input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(rv, rrd, rtag, cv, crd, ctag, cval, pf, rdy, r1, r2);
        #2;
        checkReads();
        @(posedge clk_in);
        modelUpdate();
        #1;
    endtask

    task automatic idleRead(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, r1, r2);
    endtask

    initial begin
        rst_in = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        sb.delete();
        modelReset();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;

        idleRead(5, 0);
        step(1, 3, 2, 0, 0, 0, 0, 0, 1, 3, 5);
        idleRead(3, 0);

        // Asynchronous reset mid-cycle must clear x3's busy bit before any edge.
        #2 rst_in = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5);
        #1;
        checkReads();
        @(negedge clk_in);
        rst_in = 1'b1;

        step(1, 5, 3, 0, 0, 0, 0, 0, 1, 5, 0);
        idleRead(5, 0);
        step(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 1, 5, 0);
        idleRead(5, 0);

        step(1, 7, 1, 0, 0, 0, 0, 0, 1, 7, 0);
        step(1, 7, 4, 0, 0, 0, 0, 0, 1, 7, 0);
        step(0, 0, 0, 1, 7, 1, 32'h11, 0, 1, 7, 0);
        idleRead(7, 0);

        step(1, 9, 2, 0, 0, 0, 0, 0, 1, 9, 0);
        step(1, 9, 6, 1, 9, 2, 32'h55, 0, 1, 9, 0);
        idleRead(9, 0);

        for (int i = 1; i <= 4; i++) step(1, 5'(i), 4'(i - 1), 0, 0, 0, 0, 0, 1, 5'(i), 0);
        step(1, 8, 5, 1, 2, 1, 32'h77, 1, 1, 2, 8);
        idleRead(1, 2);
        idleRead(3, 4);
        idleRead(8, 2);

        step(1, 10, 2, 1, 11, 0, 32'h9, 0, 0, 10, 11);
        idleRead(10, 11);
        step(1, 0, 5, 1, 0, 0, 32'hAB, 0, 1, 0, 0);
        idleRead(0, 0);

        for (int n = 0; n < 120; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                 $urandom, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) != 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
